// File: rtl/subservient_sram_sched.sv
// Shares one two-port byte-wide SRAM between the SERV register file and a 32-bit
// Wishbone slave; the RF always wins, Wishbone beats fill the idle port cycles.
module subservient_sram_sched #(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_rf_waddr,
  input  logic [7:0]    i_rf_wdata,
  input  logic          i_rf_wen,
  input  logic [aw-1:0] i_rf_raddr,
  input  logic          i_rf_ren,
  output logic [7:0]    o_rf_rdata,
  input  logic [aw-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata,
  output logic          o_sram_ren
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          rdone_q, rdone_d;
  logic          pend_q, pend_d;
  logic [1:0]    pidx_q, pidx_d;
  logic [31:0]   rdt_q, rdt_d;
  logic          ack_q, ack_d;
  logic          wb_wbeat, wb_rbeat;
  logic [2:0]    sel_from;
  logic [2:0]    sel_hit;
  logic [aw-1:0] beat_addr;

  // Lowest selected byte lane at or above 'from'; bit 2 flags that one exists.
  function automatic logic [2:0] find_sel(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] hit;
    hit = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      hit = (sel[k] && (k >= int'(from))) ? {1'b1, 2'(k)} : hit;
    end
    return hit;
  endfunction

  assign sel_from  = (state_q == ST_WR) ? ({1'b0, beat_q} + 3'd1) : 3'd0;
  assign sel_hit   = find_sel(i_wb_sel, sel_from);
  assign beat_addr = {i_wb_adr, beat_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      rdone_q <= 1'b0;
      pend_q  <= 1'b0;
      pidx_q  <= 2'd0;
      rdt_q   <= 32'h0000_0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdone_q <= rdone_d;
      pend_q  <= pend_d;
      pidx_q  <= pidx_d;
      rdt_q   <= rdt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rdone_d = rdone_q;
    pend_d  = 1'b0;
    pidx_d  = pidx_q;
    rdt_d   = rdt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_wb_stb && i_wb_we) begin
          state_d = sel_hit[2] ? ST_WR : ST_ACK;
          beat_d  = sel_hit[1:0];
        end else if (i_wb_stb) begin
          state_d = ST_RD;
          beat_d  = 2'd0;
          rdone_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (!i_wb_stb) begin
          state_d = ST_IDLE;
        end else if (wb_wbeat && sel_hit[2]) begin
          beat_d = sel_hit[1:0];
        end else if (wb_wbeat) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (!i_wb_stb) begin
          state_d = ST_IDLE;
        end else begin
          pend_d = wb_rbeat;
          if (wb_rbeat) begin
            pidx_d  = beat_q;
            rdone_d = (beat_q == 2'd3);
            beat_d  = (beat_q == 2'd3) ? beat_q : beat_q + 2'd1;
          end else begin
            pidx_d = pidx_q;
          end
          // Read data always belongs to the beat issued last cycle, even if the RF reads now.
          if (pend_q) begin
            rdt_d[{pidx_q, 3'b000} +: 8] = i_sram_rdata;
            state_d = (pidx_q == 2'd3) ? ST_ACK : ST_RD;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_ACK);
  end

  always_comb begin
    wb_wbeat     = (state_q == ST_WR) && i_wb_stb && !i_rf_wen;
    wb_rbeat     = (state_q == ST_RD) && i_wb_stb && !rdone_q && !i_rf_ren;
    o_sram_wen   = i_rf_wen | wb_wbeat;
    o_sram_waddr = wb_wbeat ? beat_addr : i_rf_waddr;
    o_sram_wdata = wb_wbeat ? i_wb_dat[{beat_q, 3'b000} +: 8] : i_rf_wdata;
    o_sram_ren   = i_rf_ren | wb_rbeat;
    o_sram_raddr = wb_rbeat ? beat_addr : i_rf_raddr;
  end

  assign o_rf_rdata = i_sram_rdata;
  assign o_wb_rdt   = rdt_q;
  assign o_wb_ack   = ack_q;

endmodule
